fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch datapath driven by the cycle controller (state).
//  - Owns the program counter (PC) and the 16-bit instruction register (IR).
//  - Assembles each IR from two byte reads, high byte first.
//  - Returns opcode to the controller and drives the memory address mux.
//  - Samples controller strobes on posedge clk; the controller updates them on negedge.
// PARAMETERS
//  DATA_W  8   memory data bus width; one IR byte per load_ir cycle
//  OP_W    3   opcode width, IR[2*DATA_W-1 -: OP_W]
//  ADDR_W  13  operand/PC width; OP_W+ADDR_W must equal 2*DATA_W (elaboration check)
// PORTS
//  clk       in   1       system clock; all state on posedge
//  rst       in   1       asynchronous, active-high reset
//  ena       in   1       run enable from statectl; low = synchronous flush
//  fetch     in   1       1: addr=PC (instruction fetch); 0: addr=IR operand
//  load_ir   in   1       capture data into the next IR byte
//  inc_pc    in   1       PC <= PC+1
//  load_pc   in   1       PC <= IR operand (JMP); has priority over inc_pc
//  halt      in   1       HLT decoded by the controller
//  data      in   DATA_W  memory read data
//  opcode    out  OP_W    IR[15:13], to the controller
//  ir_addr   out  ADDR_W  IR[12:0] operand address
//  pc_addr   out  ADDR_W  current PC
//  addr      out  ADDR_W  memory address = fetch ? pc_addr : ir_addr (combinational)
//  ir_valid  out  1       both IR bytes captured since the last flush
//  halted    out  1       sticky halt flag
// BEHAVIOUR
//  Reset: PC=0, IR=0, byte_sel=HI, ir_valid=0, halted=0. opcode=0 (HLT) and addr=0.
//  IR byte FSM, states HI and LO, active when ena=1 and halted=0:
//   - HI & load_ir: IR[15:8]<=data, ir_valid<=0, go to LO.
//   - LO & load_ir: IR[7:0]<=data, ir_valid<=1, go to HI.
//   - No load_ir: hold.
//   - Outputs change one posedge after the strobe (1-cycle latency).
//  PC, active when ena=1 and halted=0:
//   - load_pc: PC<=ir_addr, using the IR value before the edge.
//   - else inc_pc: PC<=PC+1 mod 2^ADDR_W; 0x1FFF wraps to 0x0000.
//   - else hold.
//  halt: at posedge with ena=1, halted<=1. While halted, PC, IR and byte_sel freeze
//   and all strobes are ignored. Cleared only by rst or ena=0.
//  ena=0 at posedge: byte_sel<=HI, ir_valid<=0, halted<=0. PC and IR hold.
//   Flushes a half-loaded IR: the next load_ir is treated as the high byte.
//  Simultaneous events:
//   - load_ir with load_pc: both act; PC takes the pre-edge operand.
//   - load_ir with halt: halt wins; no capture.
//   - inc_pc with load_pc: load_pc wins.
//  rst mid-operation: immediate asynchronous clear to the reset values. No partial byte survives.
//  X/unknown strobes are not permitted. Assertions fire if any strobe is X while ena=1.
// STRUCTURE
//  cpu_pkg (shared with state/alu):
//   - opcode localparams HLT..JMP
//   - DATA_W/OP_W/ADDR_W defaults
//   - byte_sel encoding HI=1'b0, LO=1'b1
//  Sub-module pc_counter (ADDR_W): holds PC; inputs clk, rst, en, load, inc, d; output q.
//  fetch_unit contains the IR byte FSM, the halt flag and the addr mux.
// TESTING
//  1 Reset release, ena=1; load_ir with data=8'hA0 then 8'h05 -> opcode=3'b101, ir_addr=13'h0005,
//    ir_valid=1 after the 2nd edge.
//  2 IR=16'hE123 (JMP), load_pc=1 and inc_pc=1 in the same cycle -> PC=13'h0123 next edge, no increment.
//  3 PC=13'h1FFF, inc_pc -> PC=13'h0000; with fetch=1, addr=0; with fetch=0, addr=ir_addr.
//  4 High byte loaded, then ena=0 one cycle, then ena=1; load 8'h41, 8'h22 -> IR=16'h4122,
//    ir_valid low until the 2nd byte.
//  5 halt pulse, then load_ir/inc_pc/load_pc toggled for 5 cycles -> PC and IR unchanged,
//    halted=1; ena=0 clears halted.
//  6 Assert rst between the two IR byte loads -> all outputs at reset values the same cycle
//    (asynchronous); first post-reset byte lands in IR[15:8].

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, default widths and IR byte-select encoding for the CPU blocks.
package cpu_pkg;
   localparam logic [2:0] HLT = 3'd0;
   localparam logic [2:0] SKZ = 3'd1;
   localparam logic [2:0] ADD = 3'd2;
   localparam logic [2:0] AND = 3'd3;
   localparam logic [2:0] XOR = 3'd4;
   localparam logic [2:0] LDA = 3'd5;
   localparam logic [2:0] STO = 3'd6;
   localparam logic [2:0] JMP = 3'd7;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_OP_W   = 3;
   localparam int DEF_ADDR_W = 13;
   typedef enum logic {HI = 1'b0, LO = 1'b1} byte_sel_t;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: program counter with load-over-increment priority and enable.
module pc_counter #(
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] d,
   output logic [ADDR_W-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (en) q <= load ? d : inc ? q + 1'b1 : q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns PC and the two-byte IR, tracks halt, and muxes the memory address.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OP_W   = DEF_OP_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              fetch,
   input  logic              load_ir,
   input  logic              inc_pc,
   input  logic              load_pc,
   input  logic              halt,
   input  logic [DATA_W-1:0] data,
   output logic [OP_W-1:0]   opcode,
   output logic [ADDR_W-1:0] ir_addr,
   output logic [ADDR_W-1:0] pc_addr,
   output logic [ADDR_W-1:0] addr,
   output logic              ir_valid,
   output logic              halted
);
   if (OP_W + ADDR_W != 2 * DATA_W) begin : g_width_check
      $error("fetch_unit: OP_W + ADDR_W must equal 2*DATA_W");
   end
   byte_sel_t             state, state_n;
   logic [2*DATA_W-1:0]   ir, ir_n;
   logic                  valid_n, halted_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= HI;
         ir       <= '0;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_n;
         ir       <= ir_n;
         ir_valid <= valid_n;
         halted   <= halted_n;
      end
   // halt outranks a coincident load_ir; ena=0 flushes a half-loaded IR
   always_comb begin
      state_n  = state;
      ir_n     = ir;
      valid_n  = ir_valid;
      halted_n = halted;
      if (!ena) begin
         state_n  = HI;
         valid_n  = 1'b0;
         halted_n = 1'b0;
      end else if (!halted) begin
         if (halt) halted_n = 1'b1;
         else if (load_ir) begin
            if (state == HI) ir_n[2*DATA_W-1 -: DATA_W] = data;
            else ir_n[DATA_W-1:0] = data;
            valid_n = state == LO;
            state_n = state == HI ? LO : HI;
         end
      end
   end
   pc_counter #(.ADDR_W(ADDR_W)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (ena && !halted),
      .load(load_pc),
      .inc (inc_pc),
      .d   (ir_addr),
      .q   (pc_addr)
   );
   assign opcode  = ir[2*DATA_W-1 -: OP_W];
   assign ir_addr = ir[ADDR_W-1:0];
   assign addr    = fetch ? pc_addr : ir_addr;
   always @(posedge clk)
      if (!rst && ena) assert (!$isunknown({fetch, load_ir, inc_pc, load_pc, halt}));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, corner sequences and randomized run against a behavioural model.
module tb_fetch_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        ena = 1'b0, fetch = 1'b0, load_ir = 1'b0, inc_pc = 1'b0, load_pc = 1'b0, halt = 1'b0;
   logic [7:0]  data = 8'h00;
   logic [2:0]  opcode;
   logic [12:0] ir_addr, pc_addr, addr;
   logic        ir_valid, halted;
   int tests = 0, fails = 0;
   int m_pc, m_hi_next;
   logic [15:0] m_ir;
   logic m_valid, m_halted;

   fetch_unit dut (
      .clk(clk), .rst(rst), .ena(ena), .fetch(fetch), .load_ir(load_ir), .inc_pc(inc_pc),
      .load_pc(load_pc), .halt(halt), .data(data), .opcode(opcode), .ir_addr(ir_addr),
      .pc_addr(pc_addr), .addr(addr), .ir_valid(ir_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       e, f, li, ip, lp, h;
      logic [7:0] d;
      logic [2:0] op;
      logic [12:0] ira, pc;
      logic       v, hl;
   } vec_t;
   vec_t vec[18];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 16'h0; m_hi_next = 1; m_valid = 1'b0; m_halted = 1'b0;
   endtask

   task automatic model_step();
      int next_pc;
      if (!ena) begin
         m_hi_next = 1; m_valid = 1'b0; m_halted = 1'b0;
      end else if (!m_halted) begin
         next_pc = load_pc ? int'(m_ir % 16'd8192) : inc_pc ? (m_pc + 1) % 8192 : m_pc;
         if (halt) m_halted = 1'b1;
         else if (load_ir) begin
            if (m_hi_next == 1) begin
               m_ir = {data, m_ir[7:0]}; m_valid = 1'b0; m_hi_next = 0;
            end else begin
               m_ir = {m_ir[15:8], data}; m_valid = 1'b1; m_hi_next = 1;
            end
         end
         m_pc = next_pc;
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " pc"}, pc_addr, m_pc);
      chk({tag, " opcode"}, opcode, int'(m_ir / 16'd8192));
      chk({tag, " ir_addr"}, ir_addr, int'(m_ir % 16'd8192));
      chk({tag, " addr"}, addr, fetch ? m_pc : int'(m_ir % 16'd8192));
      chk({tag, " ir_valid"}, ir_valid, m_valid);
      chk({tag, " halted"}, halted, m_halted);
   endtask

   task automatic cyc(input logic e, f, li, ip, lp, h, input logic [7:0] d);
      ena = e; fetch = f; load_ir = li; inc_pc = ip; load_pc = lp; halt = h; data = d;
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vec[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'hA0,3'd5,13'h0000,13'h0000,1'b0,1'b0};
      vec[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h05,3'd5,13'h0005,13'h0000,1'b1,1'b0};
      vec[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,3'd5,13'h0005,13'h0001,1'b1,1'b0};
      vec[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,3'd5,13'h0005,13'h0005,1'b1,1'b0};
      vec[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'hE1,3'd7,13'h0105,13'h0005,1'b0,1'b0};
      vec[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,8'h23,3'd7,13'h0123,13'h0105,1'b1,1'b0};
      vec[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,3'd7,13'h0123,13'h0123,1'b1,1'b0};
      vec[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h41,3'd2,13'h0123,13'h0123,1'b0,1'b0};
      vec[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,3'd2,13'h0123,13'h0123,1'b0,1'b0};
      vec[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h41,3'd2,13'h0123,13'h0123,1'b0,1'b0};
      vec[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h22,3'd2,13'h0122,13'h0123,1'b1,1'b0};
      vec[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,3'd2,13'h0122,13'h0123,1'b1,1'b1};
      vec[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'hFF,3'd2,13'h0122,13'h0123,1'b1,1'b1};
      vec[13] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,8'h7E,3'd2,13'h0122,13'h0123,1'b1,1'b1};
      vec[14] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'h99,3'd2,13'h0122,13'h0123,1'b1,1'b1};
      vec[15] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'h10,3'd2,13'h0122,13'h0123,1'b1,1'b1};
      vec[16] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,8'h3C,3'd2,13'h0122,13'h0123,1'b1,1'b1};
      vec[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,3'd2,13'h0122,13'h0123,1'b0,1'b0};

      model_reset();
      repeat (2) @(negedge clk);
      chk("reset pc", pc_addr, 0);
      chk("reset opcode", opcode, 0);
      chk("reset addr", addr, 0);
      chk("reset ir_valid", ir_valid, 0);
      chk("reset halted", halted, 0);
      rst = 1'b0;

      foreach (vec[i]) begin
         cyc(vec[i].e, vec[i].f, vec[i].li, vec[i].ip, vec[i].lp, vec[i].h, vec[i].d);
         chk($sformatf("vec%0d opcode", i), opcode, vec[i].op);
         chk($sformatf("vec%0d ir_addr", i), ir_addr, vec[i].ira);
         chk($sformatf("vec%0d pc", i), pc_addr, vec[i].pc);
         chk($sformatf("vec%0d addr", i), addr, vec[i].f ? vec[i].pc : vec[i].ira);
         chk($sformatf("vec%0d ir_valid", i), ir_valid, vec[i].v);
         chk($sformatf("vec%0d halted", i), halted, vec[i].hl);
         chk_model($sformatf("vec%0d model", i));
      end

      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("wrap pre pc", pc_addr, 13'h1FFF);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("wrap pc", pc_addr, 0);
      chk("wrap addr fetch", addr, 0);
      fetch = 1'b0; inc_pc = 1'b0;
      #1 chk("wrap addr operand", addr, 13'h1FFF);
      @(negedge clk);
      chk_model("wrap");

      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h9C);
      chk("pre-rst opcode", opcode, 3'd4);
      load_ir = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async rst pc", pc_addr, 0);
      chk("async rst opcode", opcode, 0);
      chk("async rst ir_addr", ir_addr, 0);
      chk("async rst addr", addr, 0);
      chk("async rst ir_valid", ir_valid, 0);
      chk("async rst halted", halted, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3A);
      chk("post-rst opcode", opcode, 3'd1);
      chk("post-rst ir_addr", ir_addr, 13'h1A00);
      chk("post-rst ir_valid", ir_valid, 0);
      chk_model("post-rst");

      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 15) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
         chk_model($sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
